z80_mailbox_ctrl: RTL
=====================

Name: z80_mailbox_ctrl

Overview:
- Controls the 68k-to-Z80 sound command and reply mailbox beside the Z80 controller in the IO block.
- Latches 68k commands and generates a timed, enable-gated NMI to the Z80.
- Serves Z80 port reads and writes for the command latch, the reply latch and NMI enable/disable.
- Tracks pending and valid flags for both directions.

Parameters:
NMI_WIDTH, 16, CLK_24M cycles nZ80NMI is held low per NMI (must be ≥ 2)

Ports:
CLK_24M  in  1  system clock
RESET  in  1  synchronous, active-high reset
M68K_DATA  in  8  68k data bus low byte
nSDZ80W  in  1  68k command-latch write strobe, active-low, async
nSDZ80R  in  1  68k reply read strobe, active-low, async
nSDZ80CLR  in  1  68k reply clear strobe, active-low, async
SDA_L  in  3  Z80 address bits [4:2] (port decode)
nIORQ  in  1  Z80 IO request, active-low
nSDRD  in  1  Z80 read strobe, active-low
nSDWR  in  1  Z80 write strobe, active-low
SDD_IN  in  8  Z80 data bus, write direction
SDD_OUT  out  8  command latch driven to Z80 data bus
SDD_OE  out  1  Z80 data bus output enable
M68K_REPLY  out  8  reply latch to 68k
nZ80NMI  out  1  Z80 NMI, active-low
CMD_PENDING  out  1  command written by 68k, not yet read by Z80
REPLY_VALID  out  1  reply written by Z80, not yet read/cleared by 68k

Behaviour:
- Port decode, gated by nIORQ low:
  - CMD_RD: SDA_L=000 with nSDRD low.
  - NMI_EN: SDA_L=010 with nSDWR low.
  - REPLY_WR: SDA_L=011 with nSDWR low.
  - NMI_DIS: SDA_L=110 with nSDWR low.
  - Other codes: ignored.
- Synchronisation: each of nSDZ80W, nSDZ80R, nSDZ80CLR and the decoded Z80 strobes passes through a 2-FF synchroniser, reset to 1 (idle).
- Edge detection:
  - "start" is the cycle the synchronised signal first reads 0.
  - "end" is the cycle it first reads 1 again.
  - State registers update on the edge following detection, i.e. 3 CLK_24M edges after the strobe is first sampled low/high.
- 68k command write (start of nSDZ80W):
  - cmd_latch <= M68K_DATA; CMD_PENDING <= 1.
  - If nmi_en=1: load nmi_cnt <= NMI_WIDTH and drive nZ80NMI low.
  - M68K_DATA must be stable from strobe fall through detection.
- NMI timer:
  - nZ80NMI = 0 while nmi_cnt ≠ 0; nmi_cnt decrements by 1 each cycle.
  - nZ80NMI is low for exactly NMI_WIDTH cycles.
  - A new command write during an active pulse reloads nmi_cnt, extending the pulse; no extra edge is produced.
- NMI enable register nmi_en:
  - Reset 0.
  - NMI_EN start sets it; NMI_DIS start clears it.
  - Clearing it mid-pulse forces nmi_cnt <= 0; nZ80NMI goes high next cycle.
  - Setting it while CMD_PENDING=1 does not generate a retroactive NMI.
- Z80 command read:
  - SDD_OE = CMD_RD decode, combinational from raw inputs, forced 0 while RESET.
  - SDD_OUT = cmd_latch at all times.
  - End of CMD_RD clears CMD_PENDING.
- Z80 reply write (start of REPLY_WR):
  - reply_latch <= SDD_IN (raw, sampled at detection); REPLY_VALID <= 1.
  - M68K_REPLY = reply_latch.
- 68k side:
  - End of nSDZ80R clears REPLY_VALID; the latch is retained.
  - Start of nSDZ80CLR: reply_latch <= 0, REPLY_VALID <= 0.
- Simultaneous events: set beats clear.
  - Command write and CMD_RD end in the same cycle: CMD_PENDING=1, latch takes the new data.
  - REPLY_WR start with nSDZ80CLR start or nSDZ80R end in the same cycle: reply_latch = SDD_IN, REPLY_VALID=1.
  - NMI_EN and NMI_DIS in the same cycle cannot occur (same bus); if forced, DIS wins.
- Reset (synchronous, any time): cmd_latch=0, reply_latch=0, nmi_en=0, nmi_cnt=0, all sync flops=1.
  - Outputs after reset: nZ80NMI=1, SDD_OE=0, SDD_OUT=0, M68K_REPLY=0, CMD_PENDING=0, REPLY_VALID=0.
  - A strobe held low across reset release is treated as a new start, 2 cycles after release.

Test Plan:
- Reset, NMI_EN OUT, 68k write 0x5A → after 3 edges CMD_PENDING=1 and nZ80NMI low for exactly 16 cycles; Z80 IN port 0 → SDD_OE=1, SDD_OUT=0x5A; CMD_PENDING=0 three edges after read end.
- nmi_en=0, 68k write 0x13 → CMD_PENDING=1, nZ80NMI stays 1; then NMI_EN → still no NMI.
- NMI_EN, two 68k writes 0x01 then 0x02 spaced 8 cycles → single low pulse of 8+16=24 cycles total; IN returns 0x02.
- Z80 OUT 0x0C data 0xA7 → M68K_REPLY=0xA7, REPLY_VALID=1; nSDZ80R pulse → REPLY_VALID=0, M68K_REPLY=0xA7; nSDZ80CLR → M68K_REPLY=0x00.
- Same-cycle 68k write 0x77 and Z80 CMD_RD end → CMD_PENDING=1, SDD_OUT=0x77; same-cycle REPLY_WR 0x3C and CLR → REPLY_VALID=1, reply 0x3C.
- RESET asserted mid-NMI pulse (cnt=7) → next edge nZ80NMI=1, all flags 0, latches 0; NMI_DIS mid-pulse → nZ80NMI high on next cycle after detection.

Source files
------------

// File: rtl/z80_mailbox_ctrl.sv
// 68k <-> Z80 sound mailbox.
//
// The 68k writes a command byte, which raises CMD_PENDING and, if NMI is
// enabled, fires a timed NMI at the Z80. The Z80 reads the command through
// port 0 and writes its reply through port 0x0C. The 68k consumes the reply
// with nSDZ80R or wipes it with nSDZ80CLR. Every strobe is asynchronous, so
// each one passes through a 2-FF synchroniser and is edge-detected before it
// touches any state.
//
// Ports:
//   CLK_24M, RESET          clock, synchronous active-high reset
//   M68K_DATA               68k data low byte, latched on a command write
//   nSDZ80W/R/CLR           68k command write / reply read / reply clear
//   SDA_L, nIORQ, nSDRD,    Z80 port decode (address bits [4:2]) and strobes
//   nSDWR, SDD_IN
//   SDD_OUT, SDD_OE         command latch onto the Z80 data bus
//   M68K_REPLY              reply latch to the 68k
//   nZ80NMI                 Z80 NMI, active-low, NMI_WIDTH cycles per pulse
//   CMD_PENDING             command written, Z80 has not finished reading it
//   REPLY_VALID             reply written, 68k has not read or cleared it
module z80_mailbox_ctrl #(
  parameter int unsigned NMI_WIDTH = 16
) (
  input  logic       CLK_24M,
  input  logic       RESET,
  input  logic [7:0] M68K_DATA,
  input  logic       nSDZ80W,
  input  logic       nSDZ80R,
  input  logic       nSDZ80CLR,
  input  logic [2:0] SDA_L,
  input  logic       nIORQ,
  input  logic       nSDRD,
  input  logic       nSDWR,
  input  logic [7:0] SDD_IN,
  output logic [7:0] SDD_OUT,
  output logic       SDD_OE,
  output logic [7:0] M68K_REPLY,
  output logic       nZ80NMI,
  output logic       CMD_PENDING,
  output logic       REPLY_VALID
);

  localparam int unsigned CntW = $clog2(NMI_WIDTH + 1);

  // Bit positions of the active-low strobes inside the synchroniser vectors.
  localparam int unsigned IdxCmdWr   = 0;
  localparam int unsigned IdxReplyRd = 1;
  localparam int unsigned IdxClr     = 2;
  localparam int unsigned IdxCmdRd   = 3;
  localparam int unsigned IdxNmiEn   = 4;
  localparam int unsigned IdxReplyWr = 5;
  localparam int unsigned IdxNmiDis  = 6;

  logic       z80_io;
  logic [6:0] raw_n;
  logic [6:0] sync1_q, sync2_q, prev_q;
  logic [6:0] start, stop;

  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      reply_q, reply_d;
  logic            pend_q, pend_d;
  logic            valid_q, valid_d;
  logic            nmi_en_q, nmi_en_d;
  logic [CntW-1:0] nmi_cnt_q, nmi_cnt_d;

  // Z80 port decode, active-low to match the 68k strobes.
  assign z80_io               = ~nIORQ;
  assign raw_n[IdxCmdWr]      = nSDZ80W;
  assign raw_n[IdxReplyRd]    = nSDZ80R;
  assign raw_n[IdxClr]        = nSDZ80CLR;
  assign raw_n[IdxCmdRd]      = ~(z80_io & ~nSDRD & (SDA_L == 3'b000));
  assign raw_n[IdxNmiEn]      = ~(z80_io & ~nSDWR & (SDA_L == 3'b010));
  assign raw_n[IdxReplyWr]    = ~(z80_io & ~nSDWR & (SDA_L == 3'b011));
  assign raw_n[IdxNmiDis]     = ~(z80_io & ~nSDWR & (SDA_L == 3'b110));

  // Sync flops and the edge-detect history all reset to idle (1), so a strobe
  // held low through reset release shows up as a fresh start.
  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
    end else begin
      sync1_q <= raw_n;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign start = prev_q & ~sync2_q;
  assign stop  = ~prev_q & sync2_q;

  always_comb begin
    cmd_d     = cmd_q;
    reply_d   = reply_q;
    pend_d    = pend_q;
    valid_d   = valid_q;
    nmi_en_d  = nmi_en_q;
    nmi_cnt_d = nmi_cnt_q;

    // Set beats clear: a new command wins over the Z80 finishing its read.
    if (start[IdxCmdWr]) begin
      cmd_d  = M68K_DATA;
      pend_d = 1'b1;
    end else if (stop[IdxCmdRd]) begin
      pend_d = 1'b0;
    end

    if (start[IdxReplyWr]) begin
      reply_d = SDD_IN;
      valid_d = 1'b1;
    end else begin
      if (stop[IdxReplyRd]) begin
        valid_d = 1'b0;
      end
      if (start[IdxClr]) begin
        reply_d = '0;
        valid_d = 1'b0;
      end
    end

    if (nmi_cnt_q != '0) begin
      nmi_cnt_d = nmi_cnt_q - CntW'(1);
    end
    // Reload rather than retrigger: a write mid-pulse only stretches it.
    if (start[IdxCmdWr] && nmi_en_q) begin
      nmi_cnt_d = CntW'(NMI_WIDTH);
    end

    // Disable wins over enable and cuts any pulse in flight.
    if (start[IdxNmiDis]) begin
      nmi_en_d  = 1'b0;
      nmi_cnt_d = '0;
    end else if (start[IdxNmiEn]) begin
      nmi_en_d = 1'b1;
    end
  end

  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      cmd_q     <= '0;
      reply_q   <= '0;
      pend_q    <= 1'b0;
      valid_q   <= 1'b0;
      nmi_en_q  <= 1'b0;
      nmi_cnt_q <= '0;
    end else begin
      cmd_q     <= cmd_d;
      reply_q   <= reply_d;
      pend_q    <= pend_d;
      valid_q   <= valid_d;
      nmi_en_q  <= nmi_en_d;
      nmi_cnt_q <= nmi_cnt_d;
    end
  end

  // Bus drive follows the raw decode so the Z80 sees data within its cycle.
  assign SDD_OE      = ~RESET & ~raw_n[IdxCmdRd];
  assign SDD_OUT     = cmd_q;
  assign M68K_REPLY  = reply_q;
  assign nZ80NMI     = (nmi_cnt_q == '0);
  assign CMD_PENDING = pend_q;
  assign REPLY_VALID = valid_q;

endmodule
